// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
//   Src_A, Src_B : operands (rs, rt), driven by the pipeline
//   MD_OP        : operation code, driven by the pipeline
//   Start        : op accepted this cycle (combinational)
//   Busy         : operation in flight (registered)
//   MDOut        : MFHI/MFLO read data
//   HI, LO       : current HI/LO registers
interface mult_div_unit_if;
  logic [31:0] Src_A;
  logic [31:0] Src_B;
  logic [3:0]  MD_OP;
  logic        Start;
  logic        Busy;
  logic [31:0] MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Src_A, Src_B, MD_OP,
    input  Start, Busy, MDOut, HI, LO
  );

  modport slave (
    input  Src_A, Src_B, MD_OP,
    output Start, Busy, MDOut, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The full result is computed at the start edge and held in pending registers; it is committed
// to HI/LO after MULT_CYCLES or DIV_CYCLES, which models the latency the hazard unit sees.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears HI/LO, Busy and any pending result
//   md    : slave side of mult_div_unit_if (operands, op code, Start/Busy, MDOut, HI/LO)
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave md
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              start;
  logic [31:0]       a, b;
  logic [63:0]       prod_s, prod_u;
  logic [31:0]       a_abs, b_abs, q_mag, r_mag;
  logic [31:0]       res_hi, res_lo;
  logic [CntW-1:0]   cycles_sel;

  assign a = md.Src_A;
  assign b = md.Src_B;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; 0x80000000 negates to itself, which is 2^31 unsigned.
  assign a_abs = a[31] ? (~a + 32'd1) : a;
  assign b_abs = b[31] ? (~b + 32'd1) : b;
  assign q_mag = (b_abs != 32'd0) ? (a_abs / b_abs) : 32'd0;
  assign r_mag = (b_abs != 32'd0) ? (a_abs % b_abs) : 32'd0;

  // Result captured at the start edge; divide by zero keeps the current HI/LO.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (md.MD_OP)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        if (b != 32'd0) begin
          res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
          res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
        end
      end
      OpDivu: begin
        if (b != 32'd0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

  assign cycles_sel = ((md.MD_OP == OpMult) || (md.MD_OP == OpMultu)) ?
                      CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = cycles_sel;
          state_d   = StBusy;
        end else if (md.MD_OP == OpMthi) begin
          hi_d = a;
        end else if (md.MD_OP == OpMtlo) begin
          lo_d = a;
        end
      end
      StBusy: begin
        // Every op code is ignored while busy; upstream is expected to stall.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    start = (state_q == StIdle) && (md.MD_OP >= OpMult) && (md.MD_OP <= OpDivu);
    case (md.MD_OP)
      OpMfhi:  md.MDOut = hi_q;
      OpMflo:  md.MDOut = lo_q;
      default: md.MDOut = 32'd0;
    endcase
  end

  assign md.Start = start;
  assign md.Busy  = (state_q == StBusy);
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table for the arithmetic ops plus hand-written
// sequences for reset, MTHI/MFHI, ops issued while busy and reset in the middle of a divide.
module tb_mult_div_unit;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  logic clk;
  logic reset;

  mult_div_unit_if bus ();

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MD_OP = op;
    bus.Src_A = a;
    bus.Src_B = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;

    //        op       a             b             pre_hi     pre_lo     hi            lo          cyc
    vec[0] = '{OpMult,  32'hFFFFFFFE, 32'd3,        32'h11,    32'h22,    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vec[1] = '{OpMultu, 32'hFFFFFFFE, 32'd3,        32'h11,    32'h22,    32'h00000002, 32'hFFFFFFFA, 5};
    vec[2] = '{OpDiv,   32'hFFFFFFF9, 32'd2,        32'h11,    32'h22,    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vec[3] = '{OpDivu,  32'd7,        32'd2,        32'h11,    32'h22,    32'h00000001, 32'h00000003, 10};
    vec[4] = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h11,    32'h22,    32'h00000000, 32'h80000000, 10};
    vec[5] = '{OpDivu,  32'd9,        32'd0,        32'd5,     32'd6,     32'h00000005, 32'h00000006, 10};
    vec[6] = '{OpDiv,   32'hFFFFFFF9, 32'd0,        32'hAAAA,  32'hBBBB,  32'h0000AAAA, 32'h0000BBBB, 10};
    vec[7] = '{OpMult,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h11,    32'h22,    32'h3FFFFFFF, 32'h00000001, 5};
    vec[8] = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'h11,    32'h22,    32'h00000001, 32'hFFFFFFFD, 10};
    vec[9] = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11,    32'h22,    32'hFFFFFFFE, 32'h00000001, 5};

    // Reset state
    drive(OpNone, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(OpMfhi, 32'd0, 32'd0);
    #1;
    check("reset_mfhi", bus.MDOut, 32'd0);
    drive(OpMflo, 32'd0, 32'd0);
    #1;
    check("reset_mflo", bus.MDOut, 32'd0);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_start", {31'd0, bus.Start}, 32'd0);
    tick();

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive(OpMthi, vec[i].pre_hi, 32'd0);
      tick();
      drive(OpMtlo, vec[i].pre_lo, 32'd0);
      tick();
      drive(vec[i].op, vec[i].a, vec[i].b);
      #1;
      check($sformatf("v%0d_start", i), {31'd0, bus.Start}, 32'd1);
      tick();
      drive(OpNone, 32'd0, 32'd0);
      n = 0;
      while (bus.Busy && n < 50) begin
        n++;
        tick();
      end
      check($sformatf("v%0d_busy_len", i), 32'(n), 32'(vec[i].cycles));
      check($sformatf("v%0d_hi", i), bus.HI, vec[i].hi);
      check($sformatf("v%0d_lo", i), bus.LO, vec[i].lo);
      drive(OpMfhi, 32'd0, 32'd0);
      #1;
      check($sformatf("v%0d_mfhi", i), bus.MDOut, vec[i].hi);
      drive(OpMflo, 32'd0, 32'd0);
      #1;
      check($sformatf("v%0d_mflo", i), bus.MDOut, vec[i].lo);
      tick();
    end

    // MTHI then MFHI
    drive(OpMthi, 32'h1234, 32'd0);
    tick();
    drive(OpMfhi, 32'd0, 32'd0);
    #1;
    check("mthi_mfhi", bus.MDOut, 32'h1234);
    tick();

    // MULT 3*4 with MFHI/MTLO/MULT issued during Busy and operands changing
    drive(OpMult, 32'd3, 32'd4);
    tick();
    n = 0;
    while (bus.Busy && n < 50) begin
      case (n % 3)
        0:       drive(OpMfhi, 32'hDEAD, 32'd9);
        1:       drive(OpMtlo, 32'hDEAD, 32'd9);
        default: drive(OpMult, 32'hDEAD, 32'd9);
      endcase
      #1;
      if (n == 0) check("busy_mfhi_old", bus.MDOut, 32'h1234);
      if (n == 2) check("busy_no_start", {31'd0, bus.Start}, 32'd0);
      n++;
      tick();
    end
    drive(OpNone, 32'd0, 32'd0);
    check("busy_len_ignored", 32'(n), 32'd5);
    check("busy_hi", bus.HI, 32'd0);
    check("busy_lo", bus.LO, 32'd12);
    tick();
    check("busy_no_restart", {31'd0, bus.Busy}, 32'd0);

    // Reset asserted in cycle 3 of a DIV
    drive(OpMthi, 32'h77, 32'd0);
    tick();
    drive(OpDiv, 32'd100, 32'd7);
    tick();
    drive(OpNone, 32'd0, 32'd0);
    tick();
    tick();
    check("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_busy", {31'd0, bus.Busy}, 32'd0);
    check("async_hi", bus.HI, 32'd0);
    check("async_lo", bus.LO, 32'd0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("after_reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("after_reset_hi", bus.HI, 32'd0);
    check("after_reset_lo", bus.LO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
